// File: rtl/dma_mc_pkg.sv
// Shared types and widths for the multi-channel DMA write engine.
package dma_mc_pkg;

  localparam int BEAT_BYTES = 64;
  localparam int CTX_ADDR_W = 64;
  localparam int CTX_LEN_W  = 32;

  typedef enum logic [1:0] {ENG_ARB, ENG_CMD, ENG_DATA} eng_state_t;
  typedef enum logic {CH_IDLE, CH_ACTIVE} ch_state_t;

  typedef struct packed {
    logic [CTX_ADDR_W-1:0] addr;
    logic [CTX_LEN_W-1:0]  remaining;
    logic [CTX_LEN_W-1:0]  chunk;
    logic [23:0]           beat_idx;
    logic [31:0]           cmd_cnt;
  } ch_ctx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant and index from the request vector.
// The priority pointer moves to the slot after the winner on each accept pulse.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          accept,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_vld
);

  logic [IW-1:0] ptr_q, ptr_d;
  int            idx;

  // Scan from the far end so the slot nearest the pointer is written last and wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % N;
      if (req[IW'(idx)]) begin
        grant_vld = 1'b1;
        grant_idx = IW'(idx);
      end
    end
    if (grant_vld) grant[grant_idx] = 1'b1;
    ptr_d = (accept && grant_vld) ? IW'((int'(grant_idx) + 1) % N) : ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dma_write_engine_mc.sv
// Multi-channel DMA write engine: chunks each channel's transfer into commands, grants channels
// round-robin per chunk and streams {channel id, beat index} lanes on one cmd/data stream pair.
module dma_write_engine_mc import dma_mc_pkg::*; #(
  parameter  int NUM_CH     = 4,
  parameter  int DATA_WIDTH = BEAT_BYTES * 8,
  parameter  int ADDR_WIDTH = 64,
  parameter  int LEN_WIDTH  = 32,
  localparam int BB         = DATA_WIDTH / 8,
  localparam int IW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            cfg_start,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] cfg_addr,
  input  logic [NUM_CH*LEN_WIDTH-1:0]  cfg_len,
  input  logic [NUM_CH*LEN_WIDTH-1:0]  cfg_chunk,
  output logic                         m_axis_cmd_valid,
  input  logic                         m_axis_cmd_ready,
  output logic [ADDR_WIDTH-1:0]        m_axis_cmd_address,
  output logic [LEN_WIDTH-1:0]         m_axis_cmd_length,
  output logic                         m_axis_data_valid,
  input  logic                         m_axis_data_ready,
  output logic [DATA_WIDTH-1:0]        m_axis_data_data,
  output logic [BB-1:0]                m_axis_data_keep,
  output logic                         m_axis_data_last,
  output logic [NUM_CH-1:0]            sts_busy,
  output logic [NUM_CH-1:0]            sts_done,
  output logic [NUM_CH*32-1:0]         sts_cmd_cnt
);

  localparam int LOG_BB = $clog2(BB);

  ch_state_t             ch_state_q [NUM_CH];
  ch_state_t             ch_state_d [NUM_CH];
  ch_ctx_t               ctx_q [NUM_CH];
  ch_ctx_t               ctx_d [NUM_CH];
  eng_state_t            eng_q, eng_d;
  logic [IW-1:0]         sel_q, sel_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [LEN_WIDTH-1:0]  cmd_len_q, cmd_len_d;
  logic                  data_valid_q, data_valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [BB-1:0]         keep_q, keep_d;
  logic                  last_q, last_d;
  logic [LEN_WIDTH-1:0]  beats_left_q, beats_left_d;
  logic [NUM_CH-1:0]     done_q, done_d;

  logic [NUM_CH-1:0]     arb_grant;
  logic [IW-1:0]         arb_idx;
  logic                  arb_vld, arb_accept;
  logic [CTX_ADDR_W-1:0] g_addr;
  logic [CTX_LEN_W-1:0]  g_rem, g_chunk, next_rem;
  logic [LEN_WIDTH-1:0]  nbeats;
  logic [LOG_BB-1:0]     len_rem;

  function automatic logic [DATA_WIDTH-1:0] beat_pattern(input logic [IW-1:0] ch,
                                                         input logic [23:0] idx);
    logic [DATA_WIDTH-1:0] p;
    for (int l = 0; l < DATA_WIDTH / 32; l++) p[l*32 +: 32] = {8'(ch), idx};
    return p;
  endfunction

  function automatic logic [BB-1:0] keep_mask(input logic [LOG_BB-1:0] rem, input logic fin);
    logic [BB-1:0] k;
    for (int b = 0; b < BB; b++) k[b] = !fin || (rem == '0) || (b < int'(rem));
    return k;
  endfunction

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (sts_busy),
    .accept    (arb_accept),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_vld (arb_vld)
  );

  always_comb begin
    ch_state_d   = ch_state_q;
    ctx_d        = ctx_q;
    eng_d        = eng_q;
    sel_d        = sel_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_len_d    = cmd_len_q;
    data_valid_d = data_valid_q;
    data_d       = data_q;
    keep_d       = keep_q;
    last_d       = last_q;
    beats_left_d = beats_left_q;
    done_d       = '0;
    arb_accept   = 1'b0;
    next_rem     = '0;
    nbeats       = '0;
    g_addr       = '0;
    g_rem        = '0;
    g_chunk      = '0;
    len_rem      = cmd_len_q[LOG_BB-1:0];
    for (int i = 0; i < NUM_CH; i++) begin
      if (arb_grant[i]) begin
        g_addr  = ctx_q[i].addr;
        g_rem   = ctx_q[i].remaining;
        g_chunk = ctx_q[i].chunk;
      end
    end
    // Starts only land on idle channels, so they never collide with the engine's write-back.
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_start[i] && ch_state_q[i] == CH_IDLE) begin
        ctx_d[i].addr      = CTX_ADDR_W'(cfg_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
        ctx_d[i].remaining = CTX_LEN_W'(cfg_len[i*LEN_WIDTH +: LEN_WIDTH]);
        ctx_d[i].chunk     = CTX_LEN_W'(cfg_chunk[i*LEN_WIDTH +: LEN_WIDTH]);
        ctx_d[i].beat_idx  = '0;
        ctx_d[i].cmd_cnt   = '0;
        if (cfg_len[i*LEN_WIDTH +: LEN_WIDTH] == '0) done_d[i] = 1'b1;
        else                                         ch_state_d[i] = CH_ACTIVE;
      end
    end
    case (eng_q)
      ENG_ARB: begin
        if (arb_vld) begin
          arb_accept  = 1'b1;
          sel_d       = arb_idx;
          eng_d       = ENG_CMD;
          cmd_valid_d = 1'b1;
          cmd_addr_d  = ADDR_WIDTH'(g_addr);
          cmd_len_d   = LEN_WIDTH'((g_chunk == '0 || g_chunk > g_rem) ? g_rem : g_chunk);
        end
      end
      ENG_CMD: begin
        if (m_axis_cmd_ready) begin
          nbeats       = (cmd_len_q >> LOG_BB) + LEN_WIDTH'(len_rem != '0);
          cmd_valid_d  = 1'b0;
          eng_d        = ENG_DATA;
          data_valid_d = 1'b1;
          beats_left_d = nbeats;
          data_d       = beat_pattern(sel_q, ctx_q[sel_q].beat_idx);
          last_d       = (nbeats == LEN_WIDTH'(1));
          keep_d       = keep_mask(len_rem, nbeats == LEN_WIDTH'(1));
        end
      end
      ENG_DATA: begin
        if (m_axis_data_ready) begin
          ctx_d[sel_q].beat_idx = ctx_q[sel_q].beat_idx + 24'd1;
          if (last_q) begin
            data_valid_d = 1'b0;
            last_d       = 1'b0;
            eng_d        = ENG_ARB;
            next_rem     = ctx_q[sel_q].remaining - CTX_LEN_W'(cmd_len_q);
            ctx_d[sel_q].addr      = ctx_q[sel_q].addr + CTX_ADDR_W'(cmd_len_q);
            ctx_d[sel_q].remaining = next_rem;
            ctx_d[sel_q].cmd_cnt   = ctx_q[sel_q].cmd_cnt + 32'd1;
            if (next_rem == '0) begin
              ch_state_d[sel_q] = CH_IDLE;
              done_d[sel_q]     = 1'b1;
            end
          end else begin
            beats_left_d = beats_left_q - LEN_WIDTH'(1);
            data_d       = beat_pattern(sel_q, ctx_q[sel_q].beat_idx + 24'd1);
            last_d       = (beats_left_q == LEN_WIDTH'(2));
            keep_d       = keep_mask(len_rem, beats_left_q == LEN_WIDTH'(2));
          end
        end
      end
      default: eng_d = ENG_ARB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ch_state_q[i] <= CH_IDLE;
        ctx_q[i]      <= '0;
      end
      eng_q        <= ENG_ARB;
      sel_q        <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_len_q    <= '0;
      data_valid_q <= 1'b0;
      data_q       <= '0;
      keep_q       <= '0;
      last_q       <= 1'b0;
      beats_left_q <= '0;
      done_q       <= '0;
    end else begin
      ch_state_q   <= ch_state_d;
      ctx_q        <= ctx_d;
      eng_q        <= eng_d;
      sel_q        <= sel_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_len_q    <= cmd_len_d;
      data_valid_q <= data_valid_d;
      data_q       <= data_d;
      keep_q       <= keep_d;
      last_q       <= last_d;
      beats_left_q <= beats_left_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    sts_busy    = '0;
    sts_cmd_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sts_busy[i]             = (ch_state_q[i] == CH_ACTIVE);
      sts_cmd_cnt[i*32 +: 32] = ctx_q[i].cmd_cnt;
    end
  end

  assign sts_done           = done_q;
  assign m_axis_cmd_valid   = cmd_valid_q;
  assign m_axis_cmd_address = cmd_addr_q;
  assign m_axis_cmd_length  = cmd_len_q;
  assign m_axis_data_valid  = data_valid_q;
  assign m_axis_data_data   = data_q;
  assign m_axis_data_keep   = keep_q;
  assign m_axis_data_last   = last_q;

endmodule

// File: tb/tb_dma_write_engine_mc.sv
// Scoreboard bench for dma_write_engine_mc: stimulus queues expected commands/beats,
// a negedge monitor pops and compares every accepted transfer.
module tb_dma_write_engine_mc;

  localparam int NCH = 4;
  localparam int DW  = 512;
  localparam int AW  = 64;
  localparam int LW  = 32;
  localparam int BB  = DW / 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NCH-1:0]    cfg_start;
  logic [NCH*AW-1:0] cfg_addr;
  logic [NCH*LW-1:0] cfg_len;
  logic [NCH*LW-1:0] cfg_chunk;
  logic              m_axis_cmd_valid, m_axis_cmd_ready;
  logic [AW-1:0]     m_axis_cmd_address;
  logic [LW-1:0]     m_axis_cmd_length;
  logic              m_axis_data_valid, m_axis_data_ready;
  logic [DW-1:0]     m_axis_data_data;
  logic [BB-1:0]     m_axis_data_keep;
  logic              m_axis_data_last;
  logic [NCH-1:0]    sts_busy, sts_done;
  logic [NCH*32-1:0] sts_cmd_cnt;

  dma_write_engine_mc #(.NUM_CH(NCH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_addr(cfg_addr), .cfg_len(cfg_len), .cfg_chunk(cfg_chunk),
    .m_axis_cmd_valid(m_axis_cmd_valid), .m_axis_cmd_ready(m_axis_cmd_ready),
    .m_axis_cmd_address(m_axis_cmd_address), .m_axis_cmd_length(m_axis_cmd_length),
    .m_axis_data_valid(m_axis_data_valid), .m_axis_data_ready(m_axis_data_ready),
    .m_axis_data_data(m_axis_data_data), .m_axis_data_keep(m_axis_data_keep),
    .m_axis_data_last(m_axis_data_last),
    .sts_busy(sts_busy), .sts_done(sts_done), .sts_cmd_cnt(sts_cmd_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic [LW-1:0] len; } cmd_t;
  typedef struct { logic [DW-1:0] data; logic [BB-1:0] keep; logic last; } beat_t;

  cmd_t  cmd_q[$];
  beat_t beat_q[$];
  cmd_t  ecmd;
  beat_t ebeat;
  int    n_tests = 0;
  int    n_fail  = 0;
  int    done_cnt [NCH];
  int    model_idx [NCH];
  logic  bp_en = 1'b0;

  function automatic logic [DW-1:0] pat(input int ch, input int idx);
    logic [DW-1:0] p;
    for (int l = 0; l < DW / 32; l++) p[l*32 +: 32] = {ch[7:0], idx[23:0]};
    return p;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected commands and beats for one command of a channel.
  task automatic push_cmd(input int ch, input logic [AW-1:0] a, input logic [LW-1:0] l);
    beat_t bt;
    int nb  = (int'(l) + BB - 1) / BB;
    int rem = int'(l) % BB;
    cmd_q.push_back('{a, l});
    for (int b = 0; b < nb; b++) begin
      bt.data = pat(ch, model_idx[ch]);
      bt.last = (b == nb - 1);
      bt.keep = '1;
      if (b == nb - 1 && rem != 0) bt.keep = (64'd1 << rem) - 64'd1;
      beat_q.push_back(bt);
      model_idx[ch]++;
    end
  endtask

  task automatic model_single(input int ch, input logic [AW-1:0] a, input logic [LW-1:0] len,
                              input logic [LW-1:0] chunk);
    logic [LW-1:0] rem = len;
    logic [LW-1:0] l;
    model_idx[ch] = 0;
    while (rem != 0) begin
      l = (chunk == 0 || chunk > rem) ? rem : chunk;
      push_cmd(ch, a, l);
      a   = a + AW'(l);
      rem = rem - l;
    end
  endtask

  task automatic start(input int ch, input logic [AW-1:0] a, input logic [LW-1:0] l,
                       input logic [LW-1:0] c);
    cfg_addr[ch*AW +: AW]  = a;
    cfg_len[ch*LW +: LW]   = l;
    cfg_chunk[ch*LW +: LW] = c;
    cfg_start[ch]          = 1'b1;
  endtask

  task automatic pulse();
    @(posedge clk); #1;
    cfg_start = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cfg_start = '0;
    #1;
    check("rst valids/last", {m_axis_cmd_valid, m_axis_data_valid, m_axis_data_last}, 3'b000);
    check("rst busy/done", {sts_busy, sts_done}, 8'h00);
    check("rst addr/len/keep", {m_axis_cmd_address, m_axis_cmd_length, m_axis_data_keep}, 0);
    check("rst data", m_axis_data_data, 0);
    check("rst cmd_cnt", sts_cmd_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cmd_q.delete();
    beat_q.delete();
    for (int i = 0; i < NCH; i++) begin
      model_idx[i] = 0;
      done_cnt[i]  = 0;
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((cmd_q.size() != 0 || beat_q.size() != 0 || sts_busy != '0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    n_tests++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL %s timeout: %0d cmds %0d beats pending, busy %b", name, cmd_q.size(),
               beat_q.size(), sts_busy);
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] cnt_of(input int ch);
    return sts_cmd_cnt[ch*32 +: 32];
  endfunction

  // Ready drivers: tied high unless backpressure is enabled.
  initial begin
    m_axis_cmd_ready  = 1'b1;
    m_axis_data_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_en) begin
        m_axis_cmd_ready  = 1'($urandom_range(0, 1));
        m_axis_data_ready = ($urandom_range(0, 2) != 0);
      end else begin
        m_axis_cmd_ready  = 1'b1;
        m_axis_data_ready = 1'b1;
      end
    end
  end

  logic          cmd_stall = 1'b0, dat_stall = 1'b0;
  logic [AW-1:0] st_addr;
  logic [LW-1:0] st_len;
  logic [DW-1:0] st_data;
  logic [BB-1:0] st_keep;
  logic          st_last;

  always @(negedge clk) begin
    if (rst) begin
      cmd_stall = 1'b0;
      dat_stall = 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) if (sts_done[i]) done_cnt[i]++;
      if (cmd_stall)
        check("cmd held while stalled", {m_axis_cmd_valid, m_axis_cmd_address, m_axis_cmd_length},
              {1'b1, st_addr, st_len});
      if (dat_stall) begin
        check("data held while stalled", m_axis_data_data, st_data);
        check("valid/last/keep held", {m_axis_data_valid, m_axis_data_last, m_axis_data_keep},
              {1'b1, st_last, st_keep});
      end
      if (m_axis_cmd_valid && m_axis_cmd_ready) begin
        if (cmd_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected cmd: addr %0h len %0h", m_axis_cmd_address, m_axis_cmd_length);
        end else begin
          ecmd = cmd_q.pop_front();
          check("cmd address", m_axis_cmd_address, ecmd.addr);
          check("cmd length", m_axis_cmd_length, ecmd.len);
        end
      end
      if (m_axis_data_valid && m_axis_data_ready) begin
        if (beat_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected beat: data %0h", m_axis_data_data[31:0]);
        end else begin
          ebeat = beat_q.pop_front();
          check("beat data", m_axis_data_data, ebeat.data);
          check("beat keep/last", {m_axis_data_keep, m_axis_data_last}, {ebeat.keep, ebeat.last});
        end
      end
      cmd_stall = m_axis_cmd_valid && !m_axis_cmd_ready;
      dat_stall = m_axis_data_valid && !m_axis_data_ready;
      st_addr   = m_axis_cmd_address;
      st_len    = m_axis_cmd_length;
      st_data   = m_axis_data_data;
      st_keep   = m_axis_data_keep;
      st_last   = m_axis_data_last;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cfg_start = '0;
    cfg_addr  = '0;
    cfg_len   = '0;
    cfg_chunk = '0;
    #2;
    do_reset();

    // Single channel, 8 chunks of 512 beats, ready held high.
    model_single(0, 64'h1234_1234_0000, 32'h40000, 32'h8000);
    start(0, 64'h1234_1234_0000, 32'h40000, 32'h8000);
    pulse();
    check("busy after start", sts_busy, 4'b0001);
    check("no cmd in ARB cycle", m_axis_cmd_valid, 1'b0);
    @(posedge clk); #1;
    check("cmd_valid 2 cycles after start", m_axis_cmd_valid, 1'b1);
    wait_idle("ch0 large", 6000);
    check("ch0 done pulses", done_cnt[0], 1);
    check("ch0 cmd_cnt", cnt_of(0), 8);

    // Four channels started together interleave round-robin.
    do_reset();
    for (int r = 0; r < 4; r++)
      for (int ch = 0; ch < NCH; ch++)
        push_cmd(ch, AW'(ch) * 64'h1_0000 + AW'(r) * 64'h80, 32'h80);
    for (int ch = 0; ch < NCH; ch++) start(ch, AW'(ch) * 64'h1_0000, 32'h200, 32'h80);
    pulse();
    wait_idle("rr four channels", 500);
    for (int ch = 0; ch < NCH; ch++) begin
      check("rr cmd_cnt", cnt_of(ch), 4);
      check("rr done pulses", done_cnt[ch], 1);
    end

    // 100 bytes, chunk 0: one command, partial second beat of 36 bytes.
    cmd_q.push_back('{64'h0000_00AB_CD00_0000, 32'd100});
    beat_q.push_back('{pat(2, 0), 64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
    beat_q.push_back('{pat(2, 1), 64'h0000_000F_FFFF_FFFF, 1'b1});
    start(2, 64'h0000_00AB_CD00_0000, 32'd100, 32'd0);
    pulse();
    wait_idle("partial beat", 100);
    check("partial cmd_cnt", cnt_of(2), 1);

    // Random backpressure on both streams, including a partial last command.
    bp_en = 1'b1;
    model_single(1, 64'h2000_0000, 32'h2A4, 32'h100);
    start(1, 64'h2000_0000, 32'h2A4, 32'h100);
    pulse();
    wait_idle("backpressure", 2000);
    bp_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("bp cmd_cnt", cnt_of(1), 3);

    // Zero-length start: done next cycle, never busy, count cleared, no command.
    start(3, 64'h5000, 32'd0, 32'h40);
    pulse();
    check("len0 done pulse", sts_done, 4'b1000);
    check("len0 busy", sts_busy, 4'b0000);
    check("len0 cmd_cnt cleared", cnt_of(3), 0);
    @(posedge clk); #1;
    check("len0 done one cycle", sts_done, 4'b0000);
    check("len0 no cmd", m_axis_cmd_valid, 1'b0);

    // Start on a busy channel is ignored.
    done_cnt[0] = 0;
    model_single(0, 64'h8000, 32'h400, 32'h200);
    start(0, 64'h8000, 32'h400, 32'h200);
    pulse();
    repeat (5) @(posedge clk);
    #1;
    start(0, 64'hDEAD_0000, 32'h100, 32'h0);
    pulse();
    wait_idle("busy restart", 200);
    check("busy restart cmd_cnt", cnt_of(0), 2);
    check("busy restart done", done_cnt[0], 1);

    // Reset in the middle of a data burst, then a clean restart.
    model_single(1, 64'h3000_0000, 32'h1000, 32'h0);
    start(1, 64'h3000_0000, 32'h1000, 32'h0);
    pulse();
    begin
      int n = 0;
      while (!m_axis_data_valid && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      check("data started before reset", m_axis_data_valid, 1'b1);
    end
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("valids drop on reset", {m_axis_cmd_valid, m_axis_data_valid}, 2'b00);
    check("busy drops on reset", sts_busy, 4'b0000);
    do_reset();
    model_single(1, 64'h3000_0000, 32'h80, 32'h0);
    start(1, 64'h3000_0000, 32'h80, 32'h0);
    pulse();
    wait_idle("after reset", 100);
    check("after reset cmd_cnt", cnt_of(1), 1);
    check("after reset done", done_cnt[1], 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
